// File: rtl/sram_controller_pkg.sv
// Shared memory-side definitions for the SRAM controller slice.
// Holds the FSM state type, SRAM bus widths and the default SRAM base address.
package arm_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LO,
      HI,
      DONE
   } state_t;

   localparam int          SRAM_ADDR_W   = 17;
   localparam int          SRAM_DATA_W   = 16;
   localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;

   // SRAM word index of a byte address; wraps mod 2^16, low bits dropped.
   function automatic logic [15:0] word_index(
      input logic [31:0] addr,
      input logic [31:0] base
   );
      return 16'((addr - base) >> 2);
   endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Bundle between the MEM stage, the SRAM controller and the SRAM pins.
// master: pipeline + SRAM side; slave: sram_controller.
interface sram_controller_if;
   import arm_mem_pkg::*;

   logic                   wr_en;
   logic                   rd_en;
   logic [31:0]            address;
   logic [31:0]            write_data;
   logic [31:0]            read_data;
   logic                   ready;
   logic [SRAM_ADDR_W-1:0] sram_addr;
   logic [SRAM_DATA_W-1:0] sram_dq_out;
   logic [SRAM_DATA_W-1:0] sram_dq_in;
   logic                   sram_dq_oe;
   logic                   sram_we_n;

   modport master (
      output wr_en, rd_en, address, write_data, sram_dq_in,
      input  read_data, ready, sram_addr, sram_dq_out,
      input  sram_dq_oe, sram_we_n
   );

   modport slave (
      input  wr_en, rd_en, address, write_data, sram_dq_in,
      output read_data, ready, sram_addr, sram_dq_out,
      output sram_dq_oe, sram_we_n
   );

endinterface

// File: rtl/sram_controller.sv
// Splits 32-bit MEM-stage loads/stores into two 16-bit SRAM accesses (LO, HI).
// Ports: clk, rst (async, active high), bus (sram_controller_if.slave).
module sram_controller
   import arm_mem_pkg::*;
#(
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
   input logic              clk,
   input logic              rst,
   sram_controller_if.slave bus
);

   state_t                 state;
   logic [2:0]             cnt;
   logic                   op_rd;
   logic [15:0]            idx;
   logic [15:0]            wdata_hi;
   logic [15:0]            rd_lo;
   logic [31:0]            rdata;
   logic [SRAM_ADDR_W-1:0] addr_q;
   logic [SRAM_DATA_W-1:0] dq_q;
   logic                   oe_q;
   logic                   we_n_q;

   logic        req;
   logic        last;
   logic [15:0] new_idx;

   assign req     = bus.rd_en | bus.wr_en;
   assign last    = (cnt == 3'(WAIT_CYCLES));
   assign new_idx = word_index(bus.address, BASE_ADDR);

   assign bus.ready       = ((state == IDLE) && !req) || (state == DONE);
   assign bus.read_data   = rdata;
   assign bus.sram_addr   = addr_q;
   assign bus.sram_dq_out = dq_q;
   assign bus.sram_dq_oe  = oe_q;
   assign bus.sram_we_n   = we_n_q;

   // SRAM pin registers are loaded on the transition into the phase
   // they belong to, so they are valid for that phase's whole duration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         op_rd    <= 1'b0;
         idx      <= '0;
         wdata_hi <= '0;
         rd_lo    <= '0;
         rdata    <= '0;
         addr_q   <= '0;
         dq_q     <= '0;
         oe_q     <= 1'b0;
         we_n_q   <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (req) begin
                  // A load wins when both requests are present.
                  op_rd    <= bus.rd_en;
                  idx      <= new_idx;
                  wdata_hi <= bus.write_data[31:16];
                  cnt      <= '0;
                  state    <= LO;
                  addr_q   <= {new_idx, 1'b0};
                  oe_q     <= ~bus.rd_en;
                  we_n_q   <= bus.rd_en;
                  dq_q     <= bus.rd_en ? '0 : bus.write_data[15:0];
               end
            end
            LO: begin
               if (last) begin
                  cnt    <= '0;
                  state  <= HI;
                  rd_lo  <= bus.sram_dq_in;
                  addr_q <= {idx, 1'b1};
                  dq_q   <= op_rd ? '0 : wdata_hi;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            HI: begin
               if (last) begin
                  cnt    <= '0;
                  state  <= DONE;
                  addr_q <= '0;
                  dq_q   <= '0;
                  oe_q   <= 1'b0;
                  we_n_q <= 1'b1;
                  if (op_rd) begin
                     rdata <= {bus.sram_dq_in, rd_lo};
                  end
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_controller.sv
// Randomized self-checking bench for sram_controller.
// Two instances: WAIT_CYCLES=1 (main) and WAIT_CYCLES=0 (back-to-back reads).
module tb_sram_controller;

   localparam int W1 = 1;
   localparam int NW = 131072;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   sram_controller_if b1();
   sram_controller_if b0();

   sram_controller #(
      .WAIT_CYCLES(W1),
      .BASE_ADDR  (32'd1024)
   ) dut1 (
      .clk(clk),
      .rst(rst),
      .bus(b1.slave)
   );

   sram_controller #(
      .WAIT_CYCLES(0),
      .BASE_ADDR  (32'd1024)
   ) dut0 (
      .clk(clk),
      .rst(rst),
      .bus(b0.slave)
   );

   // SRAM chips attached to each controller
   logic [15:0] sram1 [0:NW-1];
   logic [15:0] sram0 [0:NW-1];
   // Reference contents of the SRAM behind dut1
   logic [15:0] ref1  [0:NW-1];

   assign b1.sram_dq_in = sram1[b1.sram_addr];
   assign b0.sram_dq_in = sram0[b0.sram_addr];

   always @(posedge clk) begin
      if (b1.sram_we_n === 1'b0) sram1[b1.sram_addr] <= b1.sram_dq_out;
      if (b0.sram_we_n === 1'b0) sram0[b0.sram_addr] <= b0.sram_dq_out;
   end

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] last_rd = 32'h0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Word index: byte offset from 1024 divided by 4, kept modulo 65536.
   function automatic logic [15:0] widx(input logic [31:0] a);
      logic [31:0] q;
      q = (a - 32'd1024) / 32'd4;
      return q[15:0];
   endfunction

   // One access on dut1, checked cycle by cycle against the model.
   task automatic acc1(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input bit scramble);
      int          lat;
      bit          done;
      bit          is_rd;
      logic        half;
      logic [15:0] ix;
      is_rd = rd;
      ix    = widx(a);
      done  = 1'b0;
      lat   = 0;
      @(posedge clk);
      #1;
      b1.rd_en      = rd;
      b1.wr_en      = wr;
      b1.address    = a;
      b1.write_data = d;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (c == 0) begin
            chk("busy_c0", b1.ready, 0);
         end else if (c <= 2 * (W1 + 1)) begin
            half = (c > W1 + 1);
            chk("sram_addr", b1.sram_addr, {ix, half});
            chk("we_n", b1.sram_we_n, is_rd);
            chk("oe", b1.sram_dq_oe, !is_rd);
            if (!is_rd)
               chk("dq_out", b1.sram_dq_out, half ? d[31:16] : d[15:0]);
            if (scramble && c == 1) begin
               b1.address    = $urandom;
               b1.write_data = $urandom;
            end
         end
         if (c > 0 && b1.ready) begin
            done = 1'b1;
            lat  = c;
         end
      end
      chk("latency", lat, 2 * (W1 + 1) + 1);
      if (is_rd) begin
         last_rd = {ref1[{ix, 1'b1}], ref1[{ix, 1'b0}]};
      end else begin
         ref1[{ix, 1'b0}] = d[15:0];
         ref1[{ix, 1'b1}] = d[31:16];
      end
      chk("read_data", b1.read_data, last_rd);
      chk("mem_lo", sram1[{ix, 1'b0}], ref1[{ix, 1'b0}]);
      chk("mem_hi", sram1[{ix, 1'b1}], ref1[{ix, 1'b1}]);
      b1.rd_en = 1'b0;
      b1.wr_en = 1'b0;
   endtask

   logic [31:0] a0 [4];
   logic [31:0] e0 [4];

   initial begin
      int          lat;
      int          k;
      bit          done;
      logic [15:0] lo;
      logic [15:0] hi;
      logic [15:0] ix;
      logic [31:0] a;
      int          op;

      rst = 1'b1;
      b1.rd_en = 1'b0; b1.wr_en = 1'b0;
      b1.address = '0; b1.write_data = '0;
      b0.rd_en = 1'b0; b0.wr_en = 1'b0;
      b0.address = '0; b0.write_data = '0;
      for (int i = 0; i < NW; i++) begin
         sram1[i] = 16'h0;
         sram0[i] = 16'h0;
         ref1[i]  = 16'h0;
      end
      sram1[2] = 16'h5678; ref1[2] = 16'h5678;
      sram1[3] = 16'h1234; ref1[3] = 16'h1234;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", b1.ready, 1);
      chk("rst_we_n", b1.sram_we_n, 1);
      chk("rst_oe", b1.sram_dq_oe, 0);
      chk("rst_rdata", b1.read_data, 0);
      chk("rst_addr", b1.sram_addr, 0);
      rst = 1'b0;

      // Store, load, store that must not touch read_data, load+store together
      acc1(0, 1, 32'd1024, 32'hDEADBEEF, 0);
      acc1(1, 0, 32'd1028, 32'h0, 0);
      acc1(0, 1, 32'd1040, 32'hA5A55A5A, 0);
      acc1(1, 1, 32'd1032, 32'h11112222, 0);
      acc1(1, 0, 32'd1024, 32'h0, 1);

      // Reset in the second HI cycle of a store, request kept asserted
      @(posedge clk);
      #1;
      b1.wr_en      = 1'b1;
      b1.address    = 32'd1048;
      b1.write_data = 32'hCAFEF00D;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      last_rd = 32'h0;
      chk("arst_we_n", b1.sram_we_n, 1);
      chk("arst_oe", b1.sram_dq_oe, 0);
      chk("arst_rdata", b1.read_data, last_rd);
      chk("arst_ready", b1.ready, 0);
      @(posedge clk);
      #2;
      rst  = 1'b0;
      done = 1'b0;
      lat  = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (c > 0 && b1.ready) begin
            done = 1'b1;
            lat  = c;
         end
      end
      chk("restart_lat", lat, 5);
      ix = widx(32'd1048);
      ref1[{ix, 1'b0}] = 16'hF00D;
      ref1[{ix, 1'b1}] = 16'hCAFE;
      chk("restart_lo", sram1[{ix, 1'b0}], ref1[{ix, 1'b0}]);
      chk("restart_hi", sram1[{ix, 1'b1}], ref1[{ix, 1'b1}]);
      b1.wr_en = 1'b0;

      // Random traffic over a small window, occasionally below the base
      for (int n = 0; n < 60; n++) begin
         op = $urandom_range(0, 2);
         if ($urandom_range(0, 7) == 0)
            a = 32'd1024 - 32'(4 * $urandom_range(1, 4));
         else
            a = 32'd1024 + 32'(4 * $urandom_range(0, 31));
         a = a + 32'($urandom_range(0, 3));
         acc1(op != 1, op != 0, a, $urandom, $urandom_range(0, 1) == 1);
      end

      // Back-to-back reads on the zero-wait instance
      a0[0] = 32'd1023;
      a0[1] = 32'd1024;
      a0[2] = 32'd1028;
      a0[3] = 32'd1100;
      for (int j = 0; j < 4; j++) begin
         lo = 16'($urandom);
         hi = 16'($urandom);
         ix = widx(a0[j]);
         sram0[{ix, 1'b0}] = lo;
         sram0[{ix, 1'b1}] = hi;
         e0[j] = {hi, lo};
      end
      @(posedge clk);
      #1;
      b0.rd_en   = 1'b1;
      b0.address = a0[0];
      k = 0;
      for (int c = 0; c < 40 && k < 4; c++) begin
         @(negedge clk);
         if (k == 0 && c == 1) chk("w0_lo_addr", b0.sram_addr, 17'h1FFFE);
         if (k == 0 && c == 2) chk("w0_hi_addr", b0.sram_addr, 17'h1FFFF);
         chk("w0_we_n", b0.sram_we_n, 1);
         if (b0.ready) begin
            chk("w0_done_cyc", c, 4 * k + 3);
            chk("w0_rdata", b0.read_data, e0[k]);
            k++;
            if (k < 4) b0.address = a0[k];
            else       b0.rd_en   = 1'b0;
         end
      end
      chk("w0_count", k, 4);
      b0.rd_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: extra cycles each SRAM half-word access is held; legal range 0..7.
REQ-002 Parameter BASE_ADDR, default 1024: byte address that maps to SRAM word 0.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 wr_en  input  1  MEM-stage store request; held stable until ready.
REQ-006 rd_en  input  1  MEM-stage load request; held stable until ready.
REQ-007 address  input  32  byte address from the ALU result.
REQ-008 write_data  input  32  store value.
REQ-009 read_data  output  32  registered load result.
REQ-010 ready  output  1  high = no access in flight; pipeline freeze is ~ready.
REQ-011 sram_addr  output  17  half-word address to SRAM.
REQ-012 sram_dq_out  output  16  write data to SRAM.
REQ-013 sram_dq_in  input  16  read data from SRAM.
REQ-014 sram_dq_oe  output  1  high = controller drives the data bus.
REQ-015 sram_we_n  output  1  active-low SRAM write strobe.

Function
REQ-016 FSM states: IDLE, LO, HI, DONE.
REQ-017 IDLE: when rd_en or wr_en is high, latch address, write_data and op type, then go to LO; rd_en wins if both are high.
REQ-018 Word index = (address - BASE_ADDR) >> 2, truncated to 16 bits; address[1:0] is ignored; no range check, so values wrap mod 2^16.
REQ-019 LO: sram_addr = {index,1'b0}; stay WAIT_CYCLES+1 cycles using a 3-bit counter cleared on entry, then go to HI.
REQ-020 HI: sram_addr = {index,1'b1}; same duration as LO, then go to DONE.
REQ-021 Write op in LO/HI: sram_dq_oe=1, sram_we_n=0, sram_dq_out = write_data[15:0] in LO and write_data[31:16] in HI.
REQ-022 Read op in LO/HI: sram_dq_oe=0, sram_we_n=1.
REQ-023 Read capture: sram_dq_in is captured on the last cycle of LO into read_data[15:0] and on the last cycle of HI into read_data[31:16]; both halves are committed to read_data on entry to DONE.
REQ-024 read_data holds its value until the next read completes; writes never change it.
REQ-025 DONE lasts one cycle, then unconditionally goes to IDLE.
REQ-026 ready = (state==IDLE and no request) or state==DONE; combinational from state and inputs.
REQ-027 Latency: request present in cycle 0 gives ready=1 in cycle 2*(WAIT_CYCLES+1)+1; cycle 5 for WAIT_CYCLES=1.
REQ-028 A request still asserted in the cycle after DONE starts a new access; there is no back-to-back bypass.
REQ-029 In IDLE and DONE: sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
REQ-030 Input changes while not in IDLE are ignored; the latched values are used.

Reset
REQ-031 rst forces state=IDLE, counter=0, read_data=0 and all latches to 0, immediately and asynchronously, even mid-access.
REQ-032 While rst is high: sram_we_n=1, sram_dq_oe=0, ready reflects IDLE.
REQ-033 An access interrupted by reset is abandoned; after rst falls it restarts only if the request is still asserted.

Structure
REQ-034 Shared package arm_mem_pkg holds the state enum, SRAM_ADDR_W=17, SRAM_DATA_W=16, and the default BASE_ADDR.
REQ-035 The wait counter is inline; no sub-module.
REQ-036 Top-level integration ANDs ~ready into every pipeline-register freeze and the IF freeze.

Verification
REQ-037 Write 0xDEADBEEF to address 1024, WAIT_CYCLES=1 -> LO sram_addr=0 with dq 0xBEEF, HI sram_addr=1 with dq 0xDEAD, we_n low 2 cycles each, ready=1 in cycle 5.
REQ-038 Read address 1028 with SRAM model returning 0x5678 at half-address 2 and 0x1234 at 3 -> read_data=0x12345678 in DONE, held through a later write.
REQ-039 rd_en and wr_en both high at address 1032 -> read performed, we_n never low, SRAM contents unchanged.
REQ-040 rst asserted in the second HI cycle of a write -> same cycle: we_n=1, oe=0, read_data=0; after release with request held, a full access restarts and ready=1 at cycle 5.
REQ-041 WAIT_CYCLES=0 with 4 back-to-back reads -> each completes in 3 cycles with an IDLE cycle between accesses; address 1023 wraps to index 0xFFFF, giving sram_addr 0x1FFFE/0x1FFFF.
